// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider:
// FSM state encoding, default width and the divide-by-zero quotient helper.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;
  localparam int DIV_WIDTH_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Low 'width' bits set; callers slice the result down to their own width.
  function automatic logic [DIV_WIDTH_MAX-1:0] all_ones_quotient(input int width);
    logic [DIV_WIDTH_MAX-1:0] ones_v;
    ones_v = {DIV_WIDTH_MAX{1'b1}};
    all_ones_quotient = ones_v >> (DIV_WIDTH_MAX - width);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle of the sequential divider; the requester drives
// the master side, the divider implements the slave side.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and subtracts the divisor if that does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   prem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;
  // The partial remainder stays below the divisor, so its top bit never matters.
  logic           unused_prem_msb_s;

  assign unused_prem_msb_s = prem[WIDTH];
  assign shifted_s         = {prem[WIDTH-1:0], q_msb};
  assign trial_s           = shifted_s - {1'b0, divisor};

  // Keep the trial difference only when no borrow occurred.
  always_comb begin
    prem_nxt = shifted_s;
    q_bit    = 1'b0;
    if (trial_s[WIDTH] == 1'b0) begin
      prem_nxt = trial_s;
      q_bit    = 1'b1;
    end else begin
      prem_nxt = shifted_s;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// registered results that hold until the next operation completes.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  dif
);

  localparam int                       CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]         CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [DIV_WIDTH_MAX-1:0] ONES_FULL = all_ones_quotient(WIDTH);
  localparam logic [WIDTH-1:0]         QUOT_ONES = ONES_FULL[WIDTH-1:0];

  div_state_e       state_r;
  div_state_e       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   prem_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH:0]   prem_nxt_s;
  logic             q_bit_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             accept_s;
  logic             divisor_zero_s;
  logic             last_iter_s;

  assign accept_s       = (state_r == IDLE) && dif.start;
  assign divisor_zero_s = (dif.divisor == {WIDTH{1'b0}});
  assign last_iter_s    = (state_r == CALC) && (cnt_r == CNT_ONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem_r),
    .q_msb    (q_r[WIDTH-1]),
    .divisor  (divisor_r),
    .prem_nxt (prem_nxt_s),
    .q_bit    (q_bit_s)
  );

  // State register together with the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dif.start && divisor_zero_s) begin
          next_state_s = FIN;
        end else if (dif.start) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_ONE) begin
          next_state_s = FIN;
        end else begin
          next_state_s = CALC;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Flag values for the coming cycle, registered above.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      CALC:    busy_nxt_s = 1'b1;
      FIN:     done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Working registers: load on an accepted start, iterate while in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      prem_r    <= {(WIDTH+1){1'b0}};
      divisor_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r     <= CNT_LOAD;
      q_r       <= dif.dividend;
      prem_r    <= {(WIDTH+1){1'b0}};
      divisor_r <= dif.divisor;
    end else if (state_r == CALC) begin
      cnt_r  <= cnt_r - CNT_ONE;
      q_r    <= {q_r[WIDTH-2:0], q_bit_s};
      prem_r <= prem_nxt_s;
    end
  end

  // Result registers change only when FIN is entered; the flag clears on a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else if (accept_s && divisor_zero_s) begin
      quotient_r  <= QUOT_ONES;
      remainder_r <= dif.dividend;
      dbz_r       <= 1'b1;
    end else if (accept_s) begin
      dbz_r <= 1'b0;
    end else if (last_iter_s) begin
      quotient_r  <= {q_r[WIDTH-2:0], q_bit_s};
      remainder_r <= prem_nxt_s[WIDTH-1:0];
    end
  end

  assign dif.busy        = busy_r;
  assign dif.done        = done_r;
  assign dif.quotient    = quotient_r;
  assign dif.remainder   = remainder_r;
  assign dif.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios plus all
// operand pairs in random order, checked against plain integer division.
module tb_seq_restoring_divider;

  localparam int W    = 4;
  localparam int ONES = (1 << W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? ONES : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input int b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE; reports cycles to done and busy cycles,
  // then steps once more so the caller is back in IDLE.
  task automatic run_op(input int a, input int b, output int lat, output int busy_cyc);
    dif.dividend = W'(a);
    dif.divisor  = W'(b);
    dif.start    = 1'b1;
    tick();
    dif.start = 1'b0;
    lat       = 1;
    busy_cyc  = (dif.busy === 1'b1) ? 1 : 0;
    while (dif.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (dif.busy === 1'b1) busy_cyc++;
    end
    if (dif.done !== 1'b1) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) tick();
    checks++;
    if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_directed(input string name, input int a, input int b);
    int lat, bc;
    run_op(a, b, lat, bc);
    checks++;
    if (lat != ref_lat(b)) begin
      failures++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, ref_lat(b));
    end
    checks++;
    if (bc != ((b == 0) ? 0 : W)) begin
      failures++;
      $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, (b == 0) ? 0 : W);
    end
    checks++;
    if (dif.quotient !== W'(ref_q(a, b)) || dif.remainder !== W'(ref_r(a, b))) begin
      failures++;
      $display("FAIL %s_result got q=%0d r=%0d want q=%0d r=%0d", name,
               dif.quotient, dif.remainder, ref_q(a, b), ref_r(a, b));
    end
    checks++;
    if (dif.div_by_zero !== (b == 0)) begin
      failures++;
      $display("FAIL %s_dbz got %b want %b", name, dif.div_by_zero, b == 0);
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    int q_seen, r_seen;
    dones = 0; q_seen = -1; r_seen = -1;
    dif.dividend = W'(15);
    dif.divisor  = W'(1);
    dif.start    = 1'b1;
    tick();
    dif.start = 1'b0;
    tick();
    dif.dividend = W'(9);
    dif.divisor  = W'(2);
    dif.start    = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (dif.done === 1'b1) begin
        dones++;
        q_seen = int'(dif.quotient);
        r_seen = int'(dif.remainder);
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignored_start_done_count got %0d want 1", dones);
    end
    checks++;
    if (q_seen != 15 || r_seen != 0) begin
      failures++;
      $display("FAIL ignored_start_result got q=%0d r=%0d want q=15 r=0", q_seen, r_seen);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones, lat, bc;
    dones = 0;
    dif.dividend = W'(14);
    dif.divisor  = W'(3);
    dif.start    = 1'b1;
    tick();
    dif.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== '0) begin
      failures++;
      $display("FAIL midop_reset_outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (dif.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midop_no_done got %0d done pulses want 0", dones);
    end
    run_op(14, 3, lat, bc);
    checks++;
    if (lat != W + 1 || dif.quotient !== W'(4) || dif.remainder !== W'(2)) begin
      failures++;
      $display("FAIL midop_recover got lat=%0d q=%0d r=%0d want lat=%0d q=4 r=2",
               lat, dif.quotient, dif.remainder, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int av[6], bv[6];
    int gap;
    for (int k = 0; k < 6; k++) begin
      av[k] = int'($urandom_range(0, ONES));
      bv[k] = int'($urandom_range(0, ONES));
    end
    bv[2] = 0;
    dif.dividend = W'(av[0]);
    dif.divisor  = W'(bv[0]);
    dif.start    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      tick();
      gap++;
      while (dif.done !== 1'b1 && gap < 40) begin
        tick();
        gap++;
      end
      checks++;
      if (k > 0 && gap != 2 + ((bv[k] == 0) ? 0 : W)) begin
        failures++;
        $display("FAIL b2b_gap[%0d] got %0d want %0d", k, gap, 2 + ((bv[k] == 0) ? 0 : W));
      end else if (dif.quotient !== W'(ref_q(av[k], bv[k])) ||
                   dif.remainder !== W'(ref_r(av[k], bv[k])) ||
                   dif.div_by_zero !== (bv[k] == 0)) begin
        failures++;
        $display("FAIL b2b_result[%0d] %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d", k,
                 av[k], bv[k], dif.quotient, dif.remainder, dif.div_by_zero,
                 ref_q(av[k], bv[k]), ref_r(av[k], bv[k]));
      end
      if (k < 5) begin
        dif.dividend = W'(av[k+1]);
        dif.divisor  = W'(bv[k+1]);
      end
    end
    dif.start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_exhaustive();
    int pa[256], pb[256];
    int tmp, j, lat, bc, ok, good;
    for (int i = 0; i < 256; i++) begin
      pa[i] = i / 16;
      pb[i] = i % 16;
    end
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = pa[i]; pa[i] = pa[j]; pa[j] = tmp;
      tmp = pb[i]; pb[i] = pb[j]; pb[j] = tmp;
    end
    good = 0;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_op(pa[i], pb[i], lat, bc);
      ok = 1;
      checks++;
      if (pb[i] != 0) begin
        if (int'(dif.quotient) * pb[i] + int'(dif.remainder) != pa[i] ||
            int'(dif.remainder) >= pb[i] || dif.div_by_zero !== 1'b0 || lat != W + 1) ok = 0;
      end else begin
        if (dif.quotient !== W'(ONES) || dif.remainder !== W'(pa[i]) ||
            dif.div_by_zero !== 1'b1 || lat != 1) ok = 0;
      end
      if (ok == 0) begin
        failures++;
        $display("FAIL exhaustive %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d lat=%0d",
                 pa[i], pb[i], dif.quotient, dif.remainder, dif.div_by_zero, lat,
                 ref_q(pa[i], pb[i]), ref_r(pa[i], pb[i]), ref_lat(pb[i]));
      end else begin
        good++;
      end
    end
    $display("exhaustive: %0d/256 pairs correct (%0d%%)", good, good * 100 / 256);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed("basic_13_3", 13, 3);
    test_directed("small_3_7", 3, 7);
    test_directed("dbz_5_0", 5, 0);
    test_directed("after_dbz_9_4", 9, 4);
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
